// File: rtl/latch_write_arbiter.sv
// ---------------------------------------------------------------------------
// latch_write_arbiter
//
// Round-robin arbiter that serialises write requests from NREQ requesters
// onto a bank of NLATCH latch words. Each write goes through a fixed
// sequence so that the latch data bus is stable before, during and after
// the crit (enable) window:
//   IDLE -> SETUP (1) -> OPEN (OPEN_CYCLES) -> HOLD (1) -> DONE (1) -> IDLE
//
// Optional feature (macro LATCH_READBACK_EN): in HOLD the addressed latch
// word is read back through latchQ and compared with the written data; a
// mismatch sets the sticky wrErr flag, which rises together with ack.
// Without the macro wrErr is tied low and latchQ is ignored.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester write request (level, held until ack)
//   reqData    write data, requester i in [i*WIDTH +: WIDTH]
//   reqAddr    target word, requester i in [i*AW +: AW]
//   ack        one-cycle completion pulse to the granted requester
//   latchData  shared data bus to every latch word
//   latchCrit  one-hot enable per latch word
//   latchQ     data outputs of every latch word (readback)
//   busy       high whenever the FSM is not in IDLE
//   wrErr      sticky readback mismatch flag
// ---------------------------------------------------------------------------
module latch_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int NLATCH      = 4,
    parameter int OPEN_CYCLES = 2,
    localparam int AW         = (NLATCH > 1) ? $clog2(NLATCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] reqData,
    input  logic [NREQ*AW-1:0]    reqAddr,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      latchData,
    output logic [NLATCH-1:0]     latchCrit,
    input  logic [NLATCH*WIDTH-1:0] latchQ,
    output logic                  busy,
    output logic                  wrErr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_OPEN  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [3:0]    open_cnt;     // cycles already spent in OPEN
    logic [PW-1:0] rr_ptr;       // first index searched at the next grant
    logic [PW-1:0] grant_idx;
    logic [AW-1:0] cap_addr;
    logic          arb_found;
    logic [PW-1:0] arb_idx;
    logic          take_grant;

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise paths that skip the assignment would infer a latch.
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = PW'(idx);
            end
        end
    end

    assign take_grant = (state == S_IDLE) && arb_found;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (arb_found) next_state = S_SETUP;
            S_SETUP: next_state = S_OPEN;
            S_OPEN:  if (open_cnt == 4'(OPEN_CYCLES - 1)) next_state = S_HOLD;
            S_HOLD:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // All outputs are registered: they are decoded from next_state so each
    // one lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state     <= S_IDLE;
            open_cnt  <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            cap_addr  <= '0;
            latchData <= '0;
            latchCrit <= '0;
            ack       <= '0;
            busy      <= 1'b0;
        end else begin
            state <= next_state;
            open_cnt <= (state == S_OPEN) ? open_cnt + 4'd1 : 4'd0;

            // latchData doubles as the captured data register, so it can
            // only move on the IDLE -> SETUP transition.
            if (take_grant) begin
                grant_idx <= arb_idx;
                cap_addr  <= reqAddr[arb_idx*AW +: AW];
                latchData <= reqData[arb_idx*WIDTH +: WIDTH];
                rr_ptr    <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
            end

            latchCrit <= (next_state == S_OPEN) ? (NLATCH'(1) << cap_addr) : '0;
            ack       <= (next_state == S_DONE) ? (NREQ'(1) << grant_idx) : '0;
            busy      <= (next_state != S_IDLE);
        end
    end

`ifdef LATCH_READBACK_EN
    // Compare in HOLD; the flag therefore rises on the edge into DONE,
    // in the same cycle as ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrErr <= 1'b0;
        end else if (state == S_HOLD &&
                     latchQ[cap_addr*WIDTH +: WIDTH] != latchData) begin
            wrErr <= 1'b1;
        end
    end
`else
    logic unused_latch_q;
    assign unused_latch_q = ^latchQ;
    assign wrErr          = 1'b0;
`endif

endmodule
